// File: rtl/alarm_pkg.sv
// Shared encodings and default timing for the alarm link receiver and the slave FSM.
package alarm_pkg;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_ACQUIRE = 2'd1,
    RX_LOCKED  = 2'd2,
    RX_HOLD    = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    SL_RESET      = 2'd0,
    SL_FAST_SLAVE = 2'd1,
    SL_STOP       = 2'd2
  } slave_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_MIN_PERIOD  = 16;
  localparam int DEF_MAX_PERIOD  = 64;
  localparam int DEF_LOCK_COUNT  = 3;

endpackage

// File: rtl/alarm_debounce.sv
// Synchroniser plus debounce filter for the raw alarm line; reports the filtered
// level and a one-cycle pulse on each filtered rising edge.
module alarm_debounce
  import alarm_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_rise <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        // this sample is the DEB_CYCLES-th consecutive disagreement
        r_cnt   <= '0;
        r_level <= w_sync;
        r_rise  <= w_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/alarm_link_rx.sv
// Alarm heartbeat receiver: debounced edges, period check, lock FSM driving alarm_recv.
// Build option ALARM_RX_STICKY_EN: a lock timeout parks in HOLD with alarm_recv kept high.
//
// state      | meaning
// IDLE       | no heartbeat, waiting for a first edge
// ACQUIRE    | counting consecutive legal intervals towards lock
// LOCKED     | heartbeat stable, alarm_recv asserted
// HOLD       | lock lost but alarm latched until reset (sticky build only)
module alarm_link_rx
  import alarm_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int MAX_PERIOD  = DEF_MAX_PERIOD,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_line,
  output logic       alarm_recv,
  output logic       link_err,
  output logic       link_lost,
  output logic [1:0] lock_state
);

  localparam int IW = $clog2(MAX_PERIOD + 2);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [IW-1:0] INTV_TMO = IW'(MAX_PERIOD + 1);
  localparam logic [IW-1:0] INTV_MIN = IW'(MIN_PERIOD);

  logic            w_level;
  logic            w_rise;
  logic            w_edge;
  logic [IW-1:0]   r_intv;
  logic            w_tmo;
  logic            w_short;
  logic            w_legal;
  rx_state_t       r_state;
  rx_state_t       w_state_next;
  logic [GW-1:0]   r_good;
  logic [GW-1:0]   w_good_next;
  logic            r_recv;
  logic            w_recv_next;
  logic            w_err;
  logic            w_lost;

  alarm_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .i_line (alarm_line),
    .o_level(w_level),
    .o_rise (w_rise)
  );

  // a rise is only ever reported together with the new high level
  assign w_edge = w_rise & w_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_intv <= '0;
    end else if (w_edge) begin
      r_intv <= IW'(1);
    end else if (r_intv != INTV_TMO) begin
      r_intv <= r_intv + IW'(1);
    end
  end

  // a saturated counter means the interval exceeded MAX_PERIOD
  assign w_tmo   = (r_intv == INTV_TMO);
  assign w_short = (r_intv < INTV_MIN);
  assign w_legal = !w_short && !w_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_good  <= '0;
    end else begin
      r_state <= w_state_next;
      r_good  <= w_good_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good;
    case (r_state)
      RX_IDLE: begin
        if (w_edge) begin
          w_state_next = RX_ACQUIRE;
          w_good_next  = GW'(1);
        end
      end
      RX_ACQUIRE: begin
        if (w_edge) begin
          if (w_legal) begin
            w_good_next = r_good + GW'(1);
            if (r_good == GW'(LOCK_COUNT - 1)) w_state_next = RX_LOCKED;
          end else begin
            w_good_next = GW'(1);
          end
        end else if (w_tmo) begin
          w_state_next = RX_IDLE;
        end
      end
      RX_LOCKED: begin
        if (!w_edge && w_tmo) begin
`ifdef ALARM_RX_STICKY_EN
          w_state_next = RX_HOLD;
`else
          w_state_next = RX_IDLE;
`endif
        end
      end
`ifdef ALARM_RX_STICKY_EN
      RX_HOLD: begin
        w_state_next = RX_HOLD;
      end
`endif
      default: begin
        w_state_next = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    w_err       = 1'b0;
    w_lost      = 1'b0;
    w_recv_next = 1'b0;
    if (w_edge && w_short && (r_state == RX_ACQUIRE || r_state == RX_LOCKED)) w_err = 1'b1;
    if (r_state == RX_LOCKED && w_tmo && !w_edge) w_lost = 1'b1;
    if (w_state_next == RX_LOCKED || w_state_next == RX_HOLD) w_recv_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_recv <= 1'b0;
    end else begin
      r_recv <= w_recv_next;
    end
  end

  assign alarm_recv = r_recv;
  assign link_err   = w_err;
  assign link_lost  = w_lost;
  assign lock_state = r_state;

endmodule

// File: tb/tb_alarm_link_rx.sv
// Randomised heartbeat bench for alarm_link_rx, checked every cycle against an
// event-level model built from edge times and interval arithmetic.
module tb_alarm_link_rx;

  localparam int LAT   = 6;
  localparam int MINP  = 16;
  localparam int MAXP  = 64;
  localparam int LOCKN = 3;
  localparam int S_IDLE = 0, S_ACQ = 1, S_LOCK = 2, S_HOLD = 3;
`ifdef ALARM_RX_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       alarm_line;
  logic       alarm_recv;
  logic       link_err;
  logic       link_lost;
  logic [1:0] lock_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_edge;
  int m_state;
  int m_good;
  bit m_recv;
  bit prev_line;
  int edge_q[$];

  always #5 clk = ~clk;

  alarm_link_rx dut (
    .clk       (clk),
    .reset     (reset),
    .alarm_line(alarm_line),
    .alarm_recv(alarm_recv),
    .link_err  (link_err),
    .link_lost (link_lost),
    .lock_state(lock_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = S_IDLE;
    m_good    = 0;
    m_recv    = 1'b0;
    last_edge = -100000;
    prev_line = 1'b0;
    edge_q.delete();
  endtask

  task automatic model_step();
    bit e_edge = 1'b0;
    bit e_err  = 1'b0;
    bit e_lost = 1'b0;
    int dt;
    int nxt;
    if (edge_q.size() > 0 && edge_q[0] == cyc) begin
      e_edge = 1'b1;
      void'(edge_q.pop_front());
    end
    dt  = cyc - last_edge;
    nxt = m_state;
    case (m_state)
      S_IDLE: if (e_edge) begin nxt = S_ACQ; m_good = 1; end
      S_ACQ: begin
        if (e_edge) begin
          if (dt > MAXP) m_good = 1;
          else if (dt < MINP) begin e_err = 1'b1; m_good = 1; end
          else begin
            m_good++;
            if (m_good >= LOCKN) nxt = S_LOCK;
          end
        end else if (dt > MAXP) nxt = S_IDLE;
      end
      S_LOCK: begin
        if (e_edge) e_err = (dt < MINP);
        else if (dt > MAXP) begin
          e_lost = 1'b1;
          nxt = STICKY ? S_HOLD : S_IDLE;
        end
      end
      default: ;
    endcase
    chk("lock_state", lock_state, m_state);
    chk("alarm_recv", alarm_recv, m_recv);
    chk("link_err",   link_err,   e_err);
    chk("link_lost",  link_lost,  e_lost);
    if (e_edge) last_edge = cyc;
    m_state = nxt;
    m_recv  = (nxt == S_LOCK) || (nxt == S_HOLD);
  endtask

  // drive one cycle of alarm_line; genuine rises are expected as edges LAT cycles later
  task automatic step(input bit line, input bit real_rise);
    if (line && !prev_line && real_rise) edge_q.push_back(cyc + LAT);
    prev_line  = line;
    alarm_line = line;
    @(posedge clk);
    #1;
    cyc++;
    model_step();
  endtask

  task automatic pulse_gap(input int iv, input bit glitch);
    int glen = $urandom_range(1, 3);
    for (int i = 0; i < iv; i++) begin
      bit hi = (i < 5);
      bit g  = glitch && (iv >= 21) && (i >= 13) && (i < 13 + glen);
      step(hi || g, hi);
    end
  endtask

  task automatic glitches(input int reps);
    for (int r = 0; r < reps; r++) begin
      int glen = $urandom_range(1, 3);
      for (int i = 0; i < glen; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    #2;
    reset      = 1'b1;
    alarm_line = 1'b0;
    #1;
    chk("rst_recv",  alarm_recv, 0);
    chk("rst_err",   link_err,   0);
    chk("rst_lost",  link_lost,  0);
    chk("rst_state", lock_state, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
  endtask

  initial begin
    reset      = 1'b1;
    alarm_line = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    glitches(6);
    for (int k = 0; k < 5; k++) pulse_gap(32, 1'b0);
    pulse_gap(10, 1'b0);
    pulse_gap(32, 1'b0);
    pulse_gap(32, 1'b1);
    pulse_gap(150, 1'b0);
    pulse_gap(16, 1'b0);
    pulse_gap(64, 1'b0);
    pulse_gap(32, 1'b0);
    pulse_gap(65, 1'b0);
    pulse_gap(150, 1'b0);
    pulse_gap(32, 1'b0);
    pulse_gap(15, 1'b0);
    pulse_gap(16, 1'b0);
    pulse_gap(64, 1'b0);
    pulse_gap(150, 1'b0);
    for (int k = 0; k < 3; k++) pulse_gap(32, 1'b0);
    pulse_gap(150, 1'b0);
    pulse_gap(40, 1'b0);
    do_reset();

    for (int k = 0; k < 70; k++) begin
      int r = $urandom_range(0, 99);
      bit g = 1'b1 & $urandom_range(0, 1);
      if (r < 6)       do_reset();
      else if (r < 20) pulse_gap($urandom_range(9, 15), 1'b0);
      else if (r < 32) begin
        int b = $urandom_range(0, 3);
        pulse_gap((b == 0) ? 15 : (b == 1) ? 16 : (b == 2) ? 64 : 65, g);
      end
      else if (r < 38) pulse_gap($urandom_range(66, 140), g);
      else             pulse_gap($urandom_range(16, 64), g);
    end
    pulse_gap(100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
